// File: rtl/dmm_pkg.sv
// Shared definitions for the DMM acquisition path: decoded phase states and the
// {monitor[1], monitor[0], sw_pc_ctl} codes driven by the precharge/AZ sequencer.
package dmm_pkg;

    typedef enum logic [2:0] {
        PH_SYNC      = 3'd0,
        PH_PRECHARGE = 3'd1,
        PH_HI        = 3'd2,
        PH_GUARD     = 3'd3,
        PH_LO        = 3'd4
    } phase_t;

    localparam logic [2:0] ENC_LO = 3'b000;
    localparam logic [2:0] ENC_PC = 3'b010;
    localparam logic [2:0] ENC_HI = 3'b111;

    localparam logic SW_PC_SIGNAL = 1'b1;
    localparam logic SW_PC_BOOT   = 1'b0;

    function automatic logic enc_legal(input logic [2:0] e);
        return (e == ENC_LO) || (e == ENC_PC) || (e == ENC_HI);
    endfunction

endpackage

// File: rtl/sample_phase_decoder_phase_counter.sv
// Saturating phase-length counter: loads 1 on phase entry, counts held cycles,
// and flags when the count has reached the timeout limit.
module phase_counter
    import dmm_pkg::*;
#(
    parameter int CW        = 32,
    parameter int TIMEOUT_N = 40000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    output logic [CW-1:0] count,
    output logic          timeout
);

    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_N);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= ONE;
        end else begin
            count <= sat_inc(count);
        end
    end

    assign timeout = (count >= LIMIT);

endmodule

// File: rtl/sample_phase_decoder.sv
// Receive-side checker for the precharge/AZ sequencer: decodes phases, measures
// their lengths, checks HI/LO against the commanded duration and emits records.
module sample_phase_decoder
    import dmm_pkg::*;
#(
    parameter int CW        = 32,
    parameter int TOL       = 2,
    parameter int TIMEOUT_N = 40000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sw_pc_ctl,
    input  logic [1:0]    monitor,
    input  logic [CW-1:0] expected_n,
    input  logic          err_clear,
    output logic [2:0]    phase,
    output logic [CW-1:0] pc_count,
    output logic [CW-1:0] hi_count,
    output logic [CW-1:0] guard_count,
    output logic [CW-1:0] lo_count,
    output logic          result_valid,
    output logic [15:0]   sample_seq,
    output logic          err_illegal,
    output logic          err_sequence,
    output logic          err_duration,
    output logic          err_timeout
);

    localparam logic [CW:0] TOL_W = (CW+1)'(TOL);

    // Unsigned |a - b| one bit wider so neither direction can wrap.
    function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] ea;
        logic [CW:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    logic [2:0]    enc_p0;
    phase_t        state;
    phase_t        next_state;
    logic          load;
    logic          timeout;
    logic          emit;
    logic          set_illegal;
    logic          set_sequence;
    logic          set_timeout;
    logic          dur_bad;
    logic [CW-1:0] count;
    logic [CW-1:0] pc_shadow;
    logic [CW-1:0] hi_shadow;
    logic [CW-1:0] guard_shadow;

    // Stage p0: input capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enc_p0 <= ENC_LO;
        end else begin
            enc_p0 <= {monitor, sw_pc_ctl};
        end
    end

    phase_counter #(
        .CW        (CW),
        .TIMEOUT_N (TIMEOUT_N)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .count   (count),
        .timeout (timeout)
    );

    // Stage p1: phase decode; PRECHARGE and GUARD share a code, so the state decides
    always_comb begin
        next_state   = state;
        load         = 1'b0;
        emit         = 1'b0;
        set_illegal  = 1'b0;
        set_sequence = 1'b0;
        set_timeout  = 1'b0;
        if (!enc_legal(enc_p0)) begin
            set_illegal = 1'b1;
            next_state  = PH_SYNC;
            load        = 1'b1;
        end else if (state == PH_SYNC) begin
            if (enc_p0 == ENC_PC) begin
                next_state = PH_PRECHARGE;
                load       = 1'b1;
            end
        end else if (timeout) begin
            set_timeout = 1'b1;
            next_state  = PH_SYNC;
            load        = 1'b1;
        end else begin
            case (state)
                PH_PRECHARGE: begin
                    if (enc_p0 == ENC_HI) begin
                        next_state = PH_HI;
                        load       = 1'b1;
                    end else if (enc_p0 != ENC_PC) begin
                        set_sequence = 1'b1;
                    end
                end
                PH_HI: begin
                    if (enc_p0 == ENC_PC) begin
                        next_state = PH_GUARD;
                        load       = 1'b1;
                    end else if (enc_p0 != ENC_HI) begin
                        set_sequence = 1'b1;
                    end
                end
                PH_GUARD: begin
                    if (enc_p0 == ENC_LO) begin
                        next_state = PH_LO;
                        load       = 1'b1;
                    end else if (enc_p0 != ENC_PC) begin
                        set_sequence = 1'b1;
                    end
                end
                PH_LO: begin
                    if (enc_p0 == ENC_PC) begin
                        next_state = PH_PRECHARGE;
                        load       = 1'b1;
                        emit       = 1'b1;
                    end else if (enc_p0 != ENC_LO) begin
                        set_sequence = 1'b1;
                    end
                end
                default: ;
            endcase
            if (set_sequence) begin
                next_state = PH_SYNC;
                load       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            case (state)
                PH_PRECHARGE: pc_shadow    <= count;
                PH_HI:        hi_shadow    <= count;
                PH_GUARD:     guard_shadow <= count;
                default: ;
            endcase
        end
    end

    // LO length is still live in the counter on the emitting cycle
    assign dur_bad = (abs_diff(hi_shadow, expected_n) > TOL_W) ||
                     (abs_diff(count, expected_n) > TOL_W);

    // Stage p2: record and sticky flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= PH_SYNC;
            result_valid <= 1'b0;
            sample_seq   <= '0;
            pc_count     <= '0;
            hi_count     <= '0;
            guard_count  <= '0;
            lo_count     <= '0;
            err_illegal  <= 1'b0;
            err_sequence <= 1'b0;
            err_duration <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= next_state;
            result_valid <= emit;
            if (emit) begin
                pc_count    <= pc_shadow;
                hi_count    <= hi_shadow;
                guard_count <= guard_shadow;
                lo_count    <= count;
                sample_seq  <= sample_seq + 16'd1;
            end
            err_illegal  <= set_illegal        | (err_illegal  & ~err_clear);
            err_sequence <= set_sequence       | (err_sequence & ~err_clear);
            err_duration <= (emit & dur_bad)   | (err_duration & ~err_clear);
            err_timeout  <= set_timeout        | (err_timeout  & ~err_clear);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_sample_phase_decoder.sv
// Scoreboard bench for sample_phase_decoder: drives sequencer code patterns and
// compares every emitted record and error flag against bench-computed values.
module tb_sample_phase_decoder;
    import dmm_pkg::*;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    code;
    logic [2:0]    t_code;
    logic [CW-1:0] expected_n;
    logic          err_clear;

    logic          sw_pc_ctl;
    logic [1:0]    monitor;
    logic [2:0]    phase;
    logic [CW-1:0] pc_count;
    logic [CW-1:0] hi_count;
    logic [CW-1:0] guard_count;
    logic [CW-1:0] lo_count;
    logic          result_valid;
    logic [15:0]   sample_seq;
    logic          err_illegal;
    logic          err_sequence;
    logic          err_duration;
    logic          err_timeout;

    logic          to_sw;
    logic [1:0]    to_mon;
    logic [2:0]    to_phase;
    logic [CW-1:0] to_pc;
    logic [CW-1:0] to_hi;
    logic [CW-1:0] to_guard;
    logic [CW-1:0] to_lo;
    logic          to_valid;
    logic [15:0]   to_seq;
    logic          to_ill;
    logic          to_sequ;
    logic          to_dur;
    logic          to_tmo;

    always #5 clk = ~clk;

    assign monitor   = code[2:1];
    assign sw_pc_ctl = code[0];
    assign to_mon    = t_code[2:1];
    assign to_sw     = t_code[0];

    sample_phase_decoder #(.CW(CW), .TOL(2), .TIMEOUT_N(40000000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_pc_ctl    (sw_pc_ctl),
        .monitor      (monitor),
        .expected_n   (expected_n),
        .err_clear    (err_clear),
        .phase        (phase),
        .pc_count     (pc_count),
        .hi_count     (hi_count),
        .guard_count  (guard_count),
        .lo_count     (lo_count),
        .result_valid (result_valid),
        .sample_seq   (sample_seq),
        .err_illegal  (err_illegal),
        .err_sequence (err_sequence),
        .err_duration (err_duration),
        .err_timeout  (err_timeout)
    );

    sample_phase_decoder #(.CW(CW), .TOL(2), .TIMEOUT_N(50)) dut_to (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_pc_ctl    (to_sw),
        .monitor      (to_mon),
        .expected_n   (expected_n),
        .err_clear    (err_clear),
        .phase        (to_phase),
        .pc_count     (to_pc),
        .hi_count     (to_hi),
        .guard_count  (to_guard),
        .lo_count     (to_lo),
        .result_valid (to_valid),
        .sample_seq   (to_seq),
        .err_illegal  (to_ill),
        .err_sequence (to_sequ),
        .err_duration (to_dur),
        .err_timeout  (to_tmo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint pc;
        longint hi;
        longint gd;
        longint lo;
        longint seq;
    } rec_t;

    rec_t sb[$];
    rec_t mon_r;
    int   push_seq;

    task automatic push_rec(input int pc, input int hi, input int gd, input int lo);
        rec_t r;
        push_seq = push_seq + 1;
        r.pc  = pc;
        r.hi  = hi;
        r.gd  = gd;
        r.lo  = lo;
        r.seq = push_seq & 16'hFFFF;
        sb.push_back(r);
    endtask

    task automatic drive_code(input logic [2:0] c, input int n);
        code = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic chk_clean_reset();
        chk("rst_phase", phase, PH_SYNC);
        chk("rst_valid", result_valid, 0);
        chk("rst_seq", sample_seq, 0);
        chk("rst_pc", pc_count, 0);
        chk("rst_hi", hi_count, 0);
        chk("rst_guard", guard_count, 0);
        chk("rst_lo", lo_count, 0);
        chk("rst_err_ill", err_illegal, 0);
        chk("rst_err_seq", err_sequence, 0);
        chk("rst_err_dur", err_duration, 0);
        chk("rst_err_tmo", err_timeout, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_r = sb.pop_front();
                chk("rec_pc", pc_count, mon_r.pc);
                chk("rec_hi", hi_count, mon_r.hi);
                chk("rec_guard", guard_count, mon_r.gd);
                chk("rec_lo", lo_count, mon_r.lo);
                chk("rec_seq", sample_seq, mon_r.seq);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        code       = ENC_LO;
        t_code     = ENC_LO;
        expected_n = 100;
        err_clear  = 1'b0;
        push_seq   = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_clean_reset();

        // Timeout instance: hold 010 well past the 50-cycle limit
        t_code = ENC_PC;
        repeat (51) @(posedge clk);
        #1;
        chk("tmo_not_yet", to_tmo, 0);
        @(posedge clk);
        #1;
        chk("tmo_set", to_tmo, 1);
        chk("tmo_phase_sync", to_phase, PH_SYNC);
        repeat (8) @(posedge clk);
        #1;
        t_code = ENC_LO;
        chk("tmo_no_record", to_seq, 0);

        // Nominal sequencer runs, 10000-cycle precharge
        drive_code(ENC_PC, 10000); drive_code(ENC_HI, 100);
        drive_code(ENC_PC, 20);    drive_code(ENC_LO, 100);
        push_rec(10000, 100, 20, 100);
        drive_code(ENC_PC, 10000); drive_code(ENC_HI, 99);
        drive_code(ENC_PC, 20);    drive_code(ENC_LO, 101);
        push_rec(10000, 99, 20, 101);
        drive_code(ENC_PC, 10000); drive_code(ENC_HI, 102);
        drive_code(ENC_PC, 20);    drive_code(ENC_LO, 98);
        push_rec(10000, 102, 20, 98);
        drive_code(ENC_PC, 3);
        chk("nom_err_ill", err_illegal, 0);
        chk("nom_err_seq", err_sequence, 0);
        chk("nom_err_dur", err_duration, 0);
        chk("nom_err_tmo", err_timeout, 0);

        // HI of 103 is out of tolerance; record still emitted
        drive_code(ENC_PC, 17);  drive_code(ENC_HI, 103);
        drive_code(ENC_PC, 5);   drive_code(ENC_LO, 100);
        push_rec(20, 103, 5, 100);
        drive_code(ENC_PC, 3);
        chk("dur_103_set", err_duration, 1);
        clr_pulse();
        chk("dur_cleared", err_duration, 0);
        drive_code(ENC_PC, 16);  drive_code(ENC_HI, 102);
        drive_code(ENC_PC, 5);   drive_code(ENC_LO, 98);
        push_rec(20, 102, 5, 98);
        drive_code(ENC_PC, 3);
        chk("dur_102_ok", err_duration, 0);

        // Illegal code for one cycle mid-HI
        drive_code(ENC_PC, 7);   drive_code(ENC_HI, 50);
        drive_code(3'b011, 1);   drive_code(ENC_HI, 2);
        chk("ill_set", err_illegal, 1);
        chk("ill_phase_sync", phase, PH_SYNC);
        drive_code(ENC_LO, 10);
        drive_code(ENC_PC, 20);  drive_code(ENC_HI, 100);
        drive_code(ENC_PC, 5);   drive_code(ENC_LO, 100);
        push_rec(20, 100, 5, 100);
        drive_code(ENC_PC, 3);

        // PRECHARGE straight to 000
        drive_code(ENC_PC, 2);   drive_code(ENC_LO, 2);
        chk("seq_set", err_sequence, 1);
        chk("seq_phase_sync", phase, PH_SYNC);
        clr_pulse();
        chk("seq_cleared", err_sequence, 0);
        chk("ill_cleared", err_illegal, 0);
        drive_code(ENC_PC, 5);
        code = ENC_LO;
        @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        chk("seq_set_over_clear", err_sequence, 1);
        clr_pulse();

        // Reset mid-HI discards the partial cycle
        drive_code(ENC_PC, 20);  drive_code(ENC_HI, 100);
        drive_code(ENC_PC, 5);   drive_code(ENC_LO, 100);
        push_rec(20, 100, 5, 100);
        drive_code(ENC_PC, 10);  drive_code(ENC_HI, 40);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        push_seq = 0;
        chk_clean_reset();
        drive_code(ENC_HI, 10);  drive_code(ENC_LO, 10);
        drive_code(ENC_PC, 20);  drive_code(ENC_HI, 100);
        drive_code(ENC_PC, 5);   drive_code(ENC_LO, 99);
        push_rec(20, 100, 5, 99);
        drive_code(ENC_PC, 3);
        drive_code(ENC_PC, 2);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
